// File: rtl/edge_detect_multi_if.sv
// Channel bundle for edge_detect_multi: raw inputs, controls and all
// per-channel results. The master drives inputs; the detector is the slave.
interface edge_detect_multi_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sig_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] sticky;
  logic             any_event;

  modport master (
    output sig_in, mode, clr,
    input  filtered, rise_pulse, fall_pulse, edge_pulse, sticky, any_event
  );

  modport slave (
    input  sig_in, mode, clr,
    output filtered, rise_pulse, fall_pulse, edge_pulse, sticky, any_event
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise + debounce + edge detector with sticky,
// write-one-to-clear event flags. Every channel is independent.
module edge_detect_multi #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  edge_detect_multi_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] filt_dly_q;
  logic [WIDTH-1:0] rise_q, fall_q, edge_q;
  logic [WIDTH-1:0] rise_d, fall_d, edge_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw asynchronous inputs.
  // NOTE: non-blocking assignments let each stage take the previous stage's
  // old value, giving a true shift register instead of a single wire.
  // NOTE: the chain is an array of registers but still gets an explicit reset
  // so no stale level can be debounced into a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce next state: accept a new level only after it has differed
  // from the filtered level for DEBOUNCE_CYCLES consecutive samples.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_lvl[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_lvl[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge terms from filtered level vs its one-cycle-delayed copy; mode gates
  // only edge_pulse, and sticky lets a fresh pulse win over a clear.
  always_comb begin
    rise_d = filt_q & ~filt_dly_q;
    fall_d = ~filt_q & filt_dly_q;
    edge_d = '0;
    case (mode_e'(bus.mode))
      MODE_RISE: edge_d = rise_d;
      MODE_FALL: edge_d = fall_d;
      MODE_BOTH: edge_d = rise_d | fall_d;
      MODE_NONE: edge_d = '0;
      default:   edge_d = '0;
    endcase
    sticky_d = (sticky_q & ~bus.clr) | edge_q;
  end

  // Debounce, edge and sticky state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      edge_q     <= '0;
      sticky_q   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_q     <= edge_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.filtered   = filt_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.edge_pulse = edge_q;
  assign bus.sticky     = sticky_q;
  assign bus.any_event  = |sticky_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi. A behavioural model predicts the
// outputs of every clock edge; predictions are queued when inputs are driven
// and compared when the DUT output is sampled on the following falling edge.
module tb_edge_detect_multi;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  typedef struct packed {
    logic [W-1:0] filtered;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] edge_p;
    logic [W-1:0] sticky;
    logic         any;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  edge_detect_multi_if #(.WIDTH(W)) bus ();

  edge_detect_multi #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb_q[$];

  int rise_cnt [W];
  int fall_cnt [W];
  int edge_cnt [W];

  // Model state: history of synchronised samples instead of a counter.
  logic [W-1:0] m_sync [SYNC];
  logic [W-1:0] m_hist [DEB];
  logic [W-1:0] m_filt, m_filt_dly, m_rise, m_fall, m_edge, m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
    for (int k = 0; k < DEB; k++)  m_hist[k] = '0;
    m_filt = '0; m_filt_dly = '0; m_rise = '0; m_fall = '0;
    m_edge = '0; m_sticky = '0;
    sb_q.delete();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; edge_cnt[i] = 0;
    end
  endtask

  // Predict the outputs after the next rising edge given the driven inputs.
  task automatic model_tick(input logic [W-1:0] sig, input logic [1:0] md,
                            input logic [W-1:0] cl, output exp_t e);
    logic [W-1:0] s, nf, nr, nfa, ne, ns;
    logic [W-1:0] nh [DEB];
    logic all_diff;
    s = m_sync[SYNC-1];
    nh[0] = s;
    for (int k = 1; k < DEB; k++) nh[k] = m_hist[k-1];
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (nh[k][i] == m_filt[i]) all_diff = 1'b0;
      nf[i] = all_diff ? s[i] : m_filt[i];
    end
    nr  = m_filt & ~m_filt_dly;
    nfa = ~m_filt & m_filt_dly;
    case (md)
      2'b00:   ne = nr;
      2'b01:   ne = nfa;
      2'b10:   ne = nr | nfa;
      default: ne = '0;
    endcase
    ns = (m_sticky & ~cl) | m_edge;
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0]  = sig;
    m_hist     = nh;
    m_filt_dly = m_filt;
    m_filt     = nf;
    m_rise     = nr;
    m_fall     = nfa;
    m_edge     = ne;
    m_sticky   = ns;
    e = '{filtered: nf, rise: nr, fall: nfa, edge_p: ne, sticky: ns, any: |ns};
  endtask

  // One clock: queue the prediction, clock, then compare on the falling edge.
  task automatic step();
    exp_t e;
    model_tick(bus.sig_in, bus.mode, bus.clr, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("filtered",   32'(bus.filtered),   32'(e.filtered));
    check("rise_pulse", 32'(bus.rise_pulse), 32'(e.rise));
    check("fall_pulse", 32'(bus.fall_pulse), 32'(e.fall));
    check("edge_pulse", 32'(bus.edge_pulse), 32'(e.edge_p));
    check("sticky",     32'(bus.sticky),     32'(e.sticky));
    check("any_event",  32'(bus.any_event),  32'(e.any));
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] += int'(bus.rise_pulse[i]);
      fall_cnt[i] += int'(bus.fall_pulse[i]);
      edge_cnt[i] += int'(bus.edge_pulse[i]);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Bounded wait for a pulse on one channel (0 rise, 1 fall, 2 edge).
  task automatic wait_pulse(input string tag, input int ch, input int kind, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      step();
      case (kind)
        0:       seen = bus.rise_pulse[ch];
        1:       seen = bus.fall_pulse[ch];
        default: seen = bus.edge_pulse[ch];
      endcase
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_filt"},   32'(bus.filtered),   32'(0));
    check({tag, "_rise"},   32'(bus.rise_pulse), 32'(0));
    check({tag, "_fall"},   32'(bus.fall_pulse), 32'(0));
    check({tag, "_edge"},   32'(bus.edge_pulse), 32'(0));
    check({tag, "_sticky"}, 32'(bus.sticky),     32'(0));
    check({tag, "_any"},    32'(bus.any_event),  32'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.sig_in = '0;
    bus.mode   = 2'b00;
    bus.clr    = '0;
    clear_counts();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Single rise on channel 0: filtered after 6 edges, pulse at edge 7.
    bus.sig_in[0] = 1'b1;
    steps(5);
    check("t1_filt_e5", 32'(bus.filtered[0]), 32'(0));
    step();
    check("t1_filt_e6", 32'(bus.filtered[0]), 32'(1));
    check("t1_rise_e6", 32'(bus.rise_pulse[0]), 32'(0));
    step();
    check("t1_rise_e7", 32'(bus.rise_pulse[0]), 32'(1));
    check("t1_edge_e7", 32'(bus.edge_pulse[0]), 32'(1));
    check("t1_fall_e7", 32'(bus.fall_pulse[0]), 32'(0));
    step();
    check("t1_rise_e8", 32'(bus.rise_pulse[0]), 32'(0));
    check("t1_sticky",  32'(bus.sticky[0]), 32'(1));
    check("t1_any",     32'(bus.any_event), 32'(1));

    // Glitch rejection on channel 3, then a just-long-enough pulse.
    clear_counts();
    bus.sig_in[3] = 1'b1;
    steps(3);
    bus.sig_in[3] = 1'b0;
    steps(12);
    check("t2_glitch_filt",   32'(bus.filtered[3]), 32'(0));
    check("t2_glitch_sticky", 32'(bus.sticky[3]), 32'(0));
    check("t2_glitch_rises",  32'(rise_cnt[3]), 32'(0));
    bus.sig_in[3] = 1'b1;
    steps(4);
    bus.sig_in[3] = 1'b0;
    steps(20);
    check("t2_rise_count", 32'(rise_cnt[3]), 32'(1));
    check("t2_fall_count", 32'(fall_cnt[3]), 32'(1));

    // Both-edge mode then no-edge mode on channel 1, 20-cycle dwell.
    clear_counts();
    bus.mode = 2'b10;
    for (int t = 0; t < 4; t++) begin
      bus.sig_in[1] = ~bus.sig_in[1];
      steps(20);
    end
    check("t3_both_edges", 32'(edge_cnt[1]), 32'(4));
    clear_counts();
    bus.mode = 2'b11;
    step();
    check("t3_sticky_kept", 32'(bus.sticky[1]), 32'(1));
    for (int t = 0; t < 2; t++) begin
      bus.sig_in[1] = ~bus.sig_in[1];
      steps(20);
    end
    check("t3_none_edges", 32'(edge_cnt[1]), 32'(0));
    check("t3_none_rises", 32'(rise_cnt[1]), 32'(1));
    check("t3_none_falls", 32'(fall_cnt[1]), 32'(1));

    // Sticky write-one-to-clear and set-wins-over-clear on channel 2.
    bus.mode = 2'b00;
    bus.clr  = '1;
    step();
    bus.clr  = '0;
    check("t4_clr_all", 32'(bus.sticky), 32'(0));
    check("t4_any_low", 32'(bus.any_event), 32'(0));
    bus.sig_in[2] = 1'b1;
    wait_pulse("t4_rise2", 2, 0, 30);
    step();
    check("t4_sticky2_set", 32'(bus.sticky[2]), 32'(1));
    bus.clr[2] = 1'b1;
    step();
    bus.clr[2] = 1'b0;
    check("t4_sticky2_clr", 32'(bus.sticky[2]), 32'(0));
    check("t4_any_fall",    32'(bus.any_event), 32'(0));
    bus.mode = 2'b10;
    bus.sig_in[2] = 1'b0;
    wait_pulse("t4_edge2", 2, 2, 30);
    bus.clr[2] = 1'b1;
    step();
    bus.clr[2] = 1'b0;
    check("t4_set_wins", 32'(bus.sticky[2]), 32'(1));

    // All channels rise together.
    bus.mode   = 2'b00;
    bus.sig_in = '0;
    steps(15);
    bus.clr = '1;
    step();
    bus.clr = '0;
    bus.sig_in = '1;
    wait_pulse("t5_rise0", 0, 0, 30);
    check("t5_all_rise", 32'(bus.rise_pulse), 32'(8'hFF));
    step();
    check("t5_all_sticky", 32'(bus.sticky), 32'(8'hFF));

    // Asynchronous reset mid-debounce, then requalify channel 0.
    bus.sig_in = 8'h01;
    steps(4);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("t6_held");
    rst = 1'b0;
    model_reset();
    steps(6);
    check("t6_rise_e6", 32'(bus.rise_pulse), 32'(0));
    step();
    check("t6_rise_e7", 32'(bus.rise_pulse), 32'(8'h01));
    steps(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
